// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    REQ_C = 1'b0,
    REQ_H = 1'b1
  } req_id_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } port_req_t;

  // True when the byte address has bits set above the RAM's word-address span.
  function automatic logic addr_oob(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return hi != '0;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker; last_grant only moves when the caller commits a grant.
module arb_rr2 import dmem_arb_pkg::*; (
  input  logic       clk,
  input  logic       rstb,
  input  logic [1:0] req,
  input  logic       advance,
  output req_id_t    grant_id,
  output logic       grant_valid
);

  req_id_t last_grant_q;

  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_C;
    if (req == 2'b11) begin
      grant_id = (last_grant_q == REQ_C) ? REQ_H : REQ_C;
    end else if (req[REQ_H]) begin
      grant_id = REQ_H;
    end
  end

  // Reset to H so the core wins the first tie.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      last_grant_q <= REQ_H;
    end else if (advance) begin
      last_grant_q <= grant_id;
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// Core/host arbiter in front of a single-port synchronous data RAM: zero-wait writes,
// fixed-latency reads, range and protocol error flags.
module dmem_arb import dmem_arb_pkg::*; #(
  parameter int unsigned AW     = 14,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic [31:0]   c_addr,
  input  logic          c_rd_req,
  input  logic          c_wr_req,
  input  logic [3:0]    c_be,
  input  logic [31:0]   c_wr_data,
  output logic          c_rd_ready,
  output logic          c_wr_ready,
  output logic [31:0]   c_rd_data,
  input  logic [31:0]   h_addr,
  input  logic          h_rd_req,
  input  logic          h_wr_req,
  input  logic [3:0]    h_be,
  input  logic [31:0]   h_wr_data,
  output logic          h_rd_ready,
  output logic          h_wr_ready,
  output logic [31:0]   h_rd_data,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic          range_err,
  output logic          proto_err
);

  localparam int unsigned CW = $clog2(RD_LAT + 1);

  port_req_t     c_req, h_req, win;
  logic          win_oob;
  req_id_t       grant_id;
  logic          grant_valid, advance;

  state_t        state_q, state_d;
  logic [CW-1:0] lat_q, lat_d;
  req_id_t       owner_q, owner_d;
  logic          range_hit_q, range_hit_d;
  logic          range_err_q, range_err_d;
  logic          proto_err_q, proto_err_d;

  assign c_req = '{addr: c_addr, rd: c_rd_req, wr: c_wr_req, be: c_be, wdata: c_wr_data};
  assign h_req = '{addr: h_addr, rd: h_rd_req, wr: h_wr_req, be: h_be, wdata: h_wr_data};

  assign win       = (grant_id == REQ_C) ? c_req : h_req;
  assign win_oob   = addr_oob(win.addr, AW);
  assign ram_addr  = win.addr[AW+1:2];
  assign ram_wdata = win.wdata;
  assign range_err = range_err_q;
  assign proto_err = proto_err_q;

  arb_rr2 u_rr (
    .clk         (clk),
    .rstb        (rstb),
    .req         ({h_req.rd | h_req.wr, c_req.rd | c_req.wr}),
    .advance     (advance),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    owner_d     = owner_q;
    range_hit_d = range_hit_q;
    range_err_d = range_err_q;
    proto_err_d = proto_err_q | (c_rd_req & c_wr_req) | (h_rd_req & h_wr_req);
    advance     = 1'b0;
    ram_en      = 1'b0;
    ram_we      = '0;
    c_rd_ready  = 1'b0;
    c_wr_ready  = 1'b0;
    h_rd_ready  = 1'b0;
    h_wr_ready  = 1'b0;
    c_rd_data   = '0;
    h_rd_data   = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          advance     = 1'b1;
          ram_en      = ~win_oob;
          range_err_d = range_err_q | win_oob;
          // Write takes priority when a requester raises both strobes.
          if (win.wr) begin
            ram_we = win_oob ? 4'h0 : win.be;
            if (grant_id == REQ_C) c_wr_ready = 1'b1;
            else                   h_wr_ready = 1'b1;
          end else if (win.rd) begin
            owner_d     = grant_id;
            lat_d       = CW'(RD_LAT - 1);
            range_hit_d = win_oob;
            state_d     = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (lat_q == '0) begin
          state_d = IDLE;
          if (owner_q == REQ_C) begin
            c_rd_ready = 1'b1;
            c_rd_data  = range_hit_q ? 32'h0 : ram_rdata;
          end else begin
            h_rd_ready = 1'b1;
            h_rd_data  = range_hit_q ? 32'h0 : ram_rdata;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
    endcase

    // Keep the RAM and both requesters quiet while reset is asserted.
    if (!rstb) begin
      ram_en     = 1'b0;
      ram_we     = '0;
      c_rd_ready = 1'b0;
      c_wr_ready = 1'b0;
      h_rd_ready = 1'b0;
      h_wr_ready = 1'b0;
      c_rd_data  = '0;
      h_rd_data  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      owner_q     <= REQ_C;
      range_hit_q <= 1'b0;
      range_err_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      owner_q     <= owner_d;
      range_hit_q <= range_hit_d;
      range_err_q <= range_err_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: RD_LAT=1 and RD_LAT=3 instances share inputs and a behavioural RAM.
module tb_dmem_arb;

  localparam int unsigned AW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstb;
  logic [31:0]   c_addr, h_addr, c_wr_data, h_wr_data, ram_rdata;
  logic          c_rd_req, c_wr_req, h_rd_req, h_wr_req;
  logic [3:0]    c_be, h_be;

  logic          c_rd_ready1, c_wr_ready1, h_rd_ready1, h_wr_ready1, ram_en1;
  logic          range_err1, proto_err1;
  logic [31:0]   c_rd_data1, h_rd_data1, ram_wdata1;
  logic [3:0]    ram_we1;
  logic [AW-1:0] ram_addr1;
  logic          c_rd_ready3, c_wr_ready3, h_rd_ready3, h_wr_ready3, ram_en3;
  logic          range_err3, proto_err3;
  logic [31:0]   c_rd_data3, h_rd_data3, ram_wdata3;
  logic [3:0]    ram_we3;
  logic [AW-1:0] ram_addr3;

  typedef struct packed {
    logic          c_rd_ready;
    logic          c_wr_ready;
    logic [31:0]   c_rd_data;
    logic          h_rd_ready;
    logic          h_wr_ready;
    logic [31:0]   h_rd_data;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          range_err;
    logic          proto_err;
  } out_t;

  out_t o1, o3, o;
  logic sel;
  assign o1 = {c_rd_ready1, c_wr_ready1, c_rd_data1, h_rd_ready1, h_wr_ready1, h_rd_data1,
               ram_en1, ram_we1, ram_addr1, ram_wdata1, range_err1, proto_err1};
  assign o3 = {c_rd_ready3, c_wr_ready3, c_rd_data3, h_rd_ready3, h_wr_ready3, h_rd_data3,
               ram_en3, ram_we3, ram_addr3, ram_wdata3, range_err3, proto_err3};
  assign o  = sel ? o3 : o1;

  dmem_arb #(.AW(AW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rstb(rstb),
    .c_addr(c_addr), .c_rd_req(c_rd_req), .c_wr_req(c_wr_req), .c_be(c_be),
    .c_wr_data(c_wr_data), .c_rd_ready(c_rd_ready1), .c_wr_ready(c_wr_ready1),
    .c_rd_data(c_rd_data1),
    .h_addr(h_addr), .h_rd_req(h_rd_req), .h_wr_req(h_wr_req), .h_be(h_be),
    .h_wr_data(h_wr_data), .h_rd_ready(h_rd_ready1), .h_wr_ready(h_wr_ready1),
    .h_rd_data(h_rd_data1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
    .ram_rdata(ram_rdata), .range_err(range_err1), .proto_err(proto_err1)
  );

  dmem_arb #(.AW(AW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rstb(rstb),
    .c_addr(c_addr), .c_rd_req(c_rd_req), .c_wr_req(c_wr_req), .c_be(c_be),
    .c_wr_data(c_wr_data), .c_rd_ready(c_rd_ready3), .c_wr_ready(c_wr_ready3),
    .c_rd_data(c_rd_data3),
    .h_addr(h_addr), .h_rd_req(h_rd_req), .h_wr_req(h_wr_req), .h_be(h_be),
    .h_wr_data(h_wr_data), .h_rd_ready(h_rd_ready3), .h_wr_ready(h_wr_ready3),
    .h_rd_data(h_rd_data3),
    .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
    .ram_rdata(ram_rdata), .range_err(range_err3), .proto_err(proto_err3)
  );

  function automatic logic [31:0] pat(input int i);
    logic [15:0] k;
    k = 16'(i);
    return (i == 8) ? 32'hDEAD_BEEF : {k, ~k};
  endfunction

  // Behavioural RAM driven by the selected instance; non-read cycles return junk.
  logic [31:0] ram_mem [0:(1<<AW)-1];
  logic [31:0] pipe [0:3];
  logic [1:0]  lat_idx;
  logic        init_mem;
  assign ram_rdata = pipe[lat_idx];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= pat(i);
    end else if (o.ram_en) begin
      for (int b = 0; b < 4; b++)
        if (o.ram_we[b]) ram_mem[o.ram_addr][8*b +: 8] <= o.ram_wdata[8*b +: 8];
    end
    pipe[0] <= (o.ram_en && o.ram_we == 4'h0) ? ram_mem[o.ram_addr] : 32'hBAD0_BAD0;
    for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] ref_mem [0:63];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    c_addr = '0; c_rd_req = 1'b0; c_wr_req = 1'b0; c_be = '0; c_wr_data = '0;
    h_addr = '0; h_rd_req = 1'b0; h_wr_req = 1'b0; h_be = '0; h_wr_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one tick after the first active edge out of reset.
  task automatic apply_reset();
    idle_inputs();
    rstb     = 1'b0;
    init_mem = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    rstb     = 1'b1;
    step();
  endtask

  typedef struct {
    logic        c_rd, c_wr, h_rd, h_wr;
    logic [31:0] c_addr, h_addr;
    logic [3:0]  c_be, h_be;
    logic [31:0] c_wd, h_wd;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic [13:0] exp_addr;
    logic [31:0] exp_wd;
    logic        exp_cwr, exp_hwr;
  } vec_t;

  task automatic run_random(input int unsigned lat, input int ncyc);
    logic        act [2];
    logic        wr [2];
    logic [31:0] addr [2];
    logic [31:0] data [2];
    logic [3:0]  be [2];
    int          free_at, done_at, rd_owner, last, w;
    logic [31:0] rd_exp, exp_cd, exp_hd;
    logic        oob, exp_rerr, rerr_next;
    logic [3:0]  exp_rdy;
    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; data[i] = '0; be[i] = '0;
    end
    free_at = 0; done_at = -1; rd_owner = 0; last = 1;
    rd_exp = '0; exp_rerr = 1'b0; rerr_next = 1'b0;
    apply_reset();
    for (int t = 0; t < ncyc; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (!act[i] && $urandom_range(0, 2) != 0) begin
          act[i]  = 1'b1;
          wr[i]   = ($urandom_range(0, 1) == 1);
          be[i]   = 4'($urandom_range(1, 15));
          data[i] = $urandom;
          if ($urandom_range(0, 7) == 0) addr[i] = 32'h0001_0000 << $urandom_range(0, 15);
          else addr[i] = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
        end
      end
      c_rd_req = act[0] & ~wr[0]; c_wr_req = act[0] & wr[0];
      c_addr = addr[0]; c_be = be[0]; c_wr_data = data[0];
      h_rd_req = act[1] & ~wr[1]; h_wr_req = act[1] & wr[1];
      h_addr = addr[1]; h_be = be[1]; h_wr_data = data[1];

      // Transaction-level schedule: the memory is busy for 1 cycle per write, lat+1 per read.
      exp_rdy = '0; exp_cd = '0; exp_hd = '0;
      exp_rerr = exp_rerr | rerr_next;
      rerr_next = 1'b0;
      if (t == done_at) begin
        if (rd_owner == 0) begin exp_rdy[3] = 1'b1; exp_cd = rd_exp; end
        else               begin exp_rdy[1] = 1'b1; exp_hd = rd_exp; end
      end
      if (t >= free_at && (act[0] || act[1])) begin
        w = (act[0] && act[1]) ? 1 - last : (act[0] ? 0 : 1);
        last = w;
        oob = (addr[w][31:AW+2] != '0);
        rerr_next = oob;
        if (wr[w]) begin
          if (w == 0) exp_rdy[2] = 1'b1; else exp_rdy[0] = 1'b1;
          if (!oob)
            for (int b = 0; b < 4; b++)
              if (be[w][b]) ref_mem[addr[w][7:2]][8*b +: 8] = data[w][8*b +: 8];
          free_at = t + 1;
        end else begin
          rd_exp   = oob ? 32'h0 : ref_mem[addr[w][7:2]];
          rd_owner = w;
          done_at  = t + int'(lat);
          free_at  = done_at + 1;
        end
      end

      @(negedge clk);
      check($sformatf("rand_lat%0d_cyc%0d", lat, t),
            {o.c_rd_ready, o.c_wr_ready, o.h_rd_ready, o.h_wr_ready,
             o.c_rd_data, o.h_rd_data, o.range_err},
            {exp_rdy, exp_cd, exp_hd, exp_rerr});
      if (o.c_rd_ready || o.c_wr_ready) act[0] = 1'b0;
      if (o.h_rd_ready || o.h_wr_ready) act[1] = 1'b0;
      step();
    end
    idle_inputs();
  endtask

  vec_t vt [11];

  initial begin
    sel = 1'b0; lat_idx = 2'd0; init_mem = 1'b0;
    vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h3, 4'h0, 32'h1234, 32'h0,
               1'b1, 4'h3, 14'h4, 32'h1234, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h44, 4'h0, 4'hF, 32'h0, 32'hCAFE_F00D,
               1'b1, 4'hF, 14'h11, 32'hCAFE_F00D, 1'b0, 1'b1};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h30, 32'h40, 4'h5, 4'hA, 32'h1111_1111, 32'h2222_2222,
               1'b1, 4'h5, 14'hC, 32'h1111_1111, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0,
               1'b1, 4'h0, 14'h8, 32'h0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h8, 4'h0, 4'hC, 32'h0, 32'hAABB_CCDD,
               1'b1, 4'hC, 14'h2, 32'hAABB_CCDD, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0010_0000, 32'h0, 4'hF, 4'h0, 32'h5, 32'h0,
               1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0001_0000, 4'h0, 4'h0, 32'h0, 32'h0,
               1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h24, 32'h50, 4'h0, 4'hF, 32'h0, 32'h5,
               1'b1, 4'h0, 14'h9, 32'h0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 4'h0, 4'h0, 32'h0, 32'h0,
               1'b1, 4'h0, 14'h40, 32'h0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFC, 32'h0, 4'h1, 4'h0, 32'h77, 32'h0,
               1'b1, 4'h1, 14'h3FFF, 32'h77, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0, 4'hF, 4'h0, 32'h9, 32'h0,
               1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 1'b0};

    // Outputs held quiet during reset even with requests present.
    idle_inputs();
    rstb = 1'b0;
    c_wr_req = 1'b1; c_be = 4'hF; h_rd_req = 1'b1; h_addr = 32'h20;
    @(negedge clk);
    check("reset_quiet", {o.c_rd_ready, o.c_wr_ready, o.h_rd_ready, o.h_wr_ready, o.ram_en,
                          o.ram_we, o.c_rd_data, o.h_rd_data}, '0);
    apply_reset();
    @(negedge clk);
    check("reset_flags", {o.range_err, o.proto_err}, '0);

    for (int i = 0; i < 11; i++) begin
      apply_reset();
      c_rd_req = vt[i].c_rd; c_wr_req = vt[i].c_wr; c_addr = vt[i].c_addr;
      c_be = vt[i].c_be; c_wr_data = vt[i].c_wd;
      h_rd_req = vt[i].h_rd; h_wr_req = vt[i].h_wr; h_addr = vt[i].h_addr;
      h_be = vt[i].h_be; h_wr_data = vt[i].h_wd;
      @(negedge clk);
      check($sformatf("vec%0d_grant", i),
            {o.ram_en, o.ram_we, o.c_wr_ready, o.h_wr_ready, o.c_rd_ready, o.h_rd_ready},
            {vt[i].exp_en, vt[i].exp_we, vt[i].exp_cwr, vt[i].exp_hwr, 2'b00});
      if (vt[i].exp_en) check($sformatf("vec%0d_addr", i), o.ram_addr, vt[i].exp_addr);
      if (vt[i].exp_we != 4'h0) check($sformatf("vec%0d_wdata", i), o.ram_wdata, vt[i].exp_wd);
      idle_inputs();
    end

    // Read 0x20 then back-to-back read 0x24.
    apply_reset();
    c_rd_req = 1'b1; c_addr = 32'h20;
    @(negedge clk);
    check("rd_issue", {o.ram_en, o.ram_we, o.ram_addr, o.c_rd_ready}, {1'b1, 4'h0, 14'h8, 1'b0});
    step();
    @(negedge clk);
    check("rd_done", {o.c_rd_ready, o.c_rd_data}, {1'b1, 32'hDEAD_BEEF});
    step();
    c_addr = 32'h24;
    @(negedge clk);
    check("rd2_issue", {o.ram_en, o.ram_addr, o.c_rd_ready}, {1'b1, 14'h9, 1'b0});
    step();
    @(negedge clk);
    check("rd2_done", {o.c_rd_ready, o.c_rd_data}, {1'b1, pat(9)});
    step();
    idle_inputs();

    // Tie from reset: core read first, host write after, next tie back to core.
    apply_reset();
    c_rd_req = 1'b1; c_addr = 32'h40;
    h_wr_req = 1'b1; h_addr = 32'h80; h_be = 4'hF; h_wr_data = 32'h5555_AAAA;
    @(negedge clk);
    check("tie_c_first", {o.ram_en, o.ram_we, o.ram_addr, o.h_wr_ready},
          {1'b1, 4'h0, 14'h10, 1'b0});
    step();
    @(negedge clk);
    check("tie_c_done", {o.c_rd_ready, o.h_wr_ready, o.ram_en}, {1'b1, 1'b0, 1'b0});
    step();
    c_rd_req = 1'b0;
    @(negedge clk);
    check("tie_h_write", {o.h_wr_ready, o.ram_en, o.ram_we, o.ram_addr},
          {1'b1, 1'b1, 4'hF, 14'h20});
    step();
    c_wr_req = 1'b1; c_addr = 32'h4; c_be = 4'h1;
    h_addr = 32'h8; h_be = 4'h2;
    @(negedge clk);
    check("tie3_core", {o.c_wr_ready, o.h_wr_ready}, 2'b10);
    step();
    c_wr_req = 1'b0;
    @(negedge clk);
    check("tie3_host_next", {o.c_wr_ready, o.h_wr_ready}, 2'b01);
    step();
    idle_inputs();

    // Out-of-range host read.
    apply_reset();
    h_rd_req = 1'b1; h_addr = 32'h0010_0000;
    @(negedge clk);
    check("oob_issue", {o.ram_en, o.h_rd_ready}, 2'b00);
    step();
    @(negedge clk);
    check("oob_done", {o.h_rd_ready, o.h_rd_data, o.range_err}, {1'b1, 32'h0, 1'b1});
    step();
    idle_inputs();
    step();
    @(negedge clk);
    check("oob_sticky", o.range_err, 1'b1);
    step();

    // Host raises rd and wr together.
    apply_reset();
    h_rd_req = 1'b1; h_wr_req = 1'b1; h_addr = 32'h8; h_be = 4'hC; h_wr_data = 32'h0102_0304;
    @(negedge clk);
    check("proto_write", {o.h_wr_ready, o.h_rd_ready, o.ram_we, o.proto_err},
          {1'b1, 1'b0, 4'hC, 1'b0});
    step();
    idle_inputs();
    @(negedge clk);
    check("proto_flag", {o.proto_err, o.h_rd_ready}, 2'b10);
    step();
    @(negedge clk);
    check("proto_sticky", {o.proto_err, o.h_rd_ready}, 2'b10);
    step();

    // RD_LAT=3: reset in the second wait cycle discards the read.
    sel = 1'b1; lat_idx = 2'd2;
    apply_reset();
    c_rd_req = 1'b1; c_addr = 32'h20;
    @(negedge clk);
    check("l3_issue", {o.ram_en, o.c_rd_ready}, 2'b10);
    step();
    @(negedge clk);
    check("l3_wait1", o.c_rd_ready, 1'b0);
    step();
    #1;
    rstb = 1'b0;
    c_rd_req = 1'b0;
    @(negedge clk);
    check("l3_wait2_rst", o.c_rd_ready, 1'b0);
    step();
    @(negedge clk);
    rstb = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      check($sformatf("l3_no_ready%0d", k), o.c_rd_ready, 1'b0);
    end
    step();
    c_wr_req = 1'b1; c_addr = 32'h10; c_be = 4'hF;
    @(negedge clk);
    check("l3_regrant", {o.c_wr_ready, o.ram_en}, 2'b11);
    step();
    idle_inputs();

    sel = 1'b0; lat_idx = 2'd0;
    run_random(1, 1500);
    sel = 1'b1; lat_idx = 2'd2;
    run_random(3, 1500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
